// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite raster scanner.
package sprite_pkg;

  // Default sprite dimensions for the two Pokemon sprites
  localparam int PLAYER_W = 54;
  localparam int PLAYER_H = 58;
  localparam int OPP_W    = 54;
  localparam int OPP_H    = 58;

  // Screen coordinate widths of the VGA adapter
  localparam int SCR_X_BITS = 8;
  localparam int SCR_Y_BITS = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster position counters and incrementally built (optionally mirrored) ROM address.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W  = PLAYER_W,
  parameter int SPR_H  = PLAYER_H,
  parameter int ADDR_W = $clog2(SPR_W * SPR_H),
  parameter int CX_W   = $clog2(SPR_W),
  parameter int CY_W   = $clog2(SPR_H)
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              clr,
  input  logic              adv,
  input  logic              mirror_l,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              last
);

  localparam logic [CX_W-1:0]   CX_LAST   = CX_W'(SPR_W - 1);
  localparam logic [CY_W-1:0]   CY_LAST   = CY_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(SPR_W - 1);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_start;

  // A mirrored row starts at its rightmost column and walks leftwards
  assign col_start = mirror_l ? COL_LAST : '0;
  assign last      = (cx == CX_LAST) && (cy == CY_LAST);

  // Advance the raster; the address follows by +/-1 within a row and by row_base jumps between rows
  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      rom_addr <= '0;
    end else if (clr) begin
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      rom_addr <= col_start;
    end else if (adv) begin
      if (cx == CX_LAST) begin
        cx <= '0;
        if (last) begin
          cy       <= '0;
          row_base <= '0;
          rom_addr <= col_start;
        end else begin
          cy       <= cy + 1'b1;
          row_base <= row_base + ROW_STEP;
          rom_addr <= row_base + ROW_STEP + col_start;
        end
      end else begin
        cx       <= cx + 1'b1;
        rom_addr <= mirror_l ? rom_addr - 1'b1 : rom_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_raster_scanner.sv
// Walks one sprite in raster order, drives the sprite ROM address and emits
// plot strobes with screen coordinates aligned to the ROM's read data.
module sprite_raster_scanner
  import sprite_pkg::*;
#(
  parameter int SPR_W  = PLAYER_W,
  parameter int SPR_H  = PLAYER_H,
  parameter int X_BITS = SCR_X_BITS,
  parameter int Y_BITS = SCR_Y_BITS,
  localparam int ADDR_W = $clog2(SPR_W * SPR_H)
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              start,
  input  logic              enable,
  input  logic              mirror,
  input  logic [X_BITS-1:0] origin_x,
  input  logic [Y_BITS-1:0] origin_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [X_BITS-1:0] pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              plot
);

  localparam int CX_W = $clog2(SPR_W);
  localparam int CY_W = $clog2(SPR_H);

  scan_state_t       state;
  logic [X_BITS-1:0] origin_x_l;
  logic [Y_BITS-1:0] origin_y_l;
  logic              mirror_l;
  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;
  logic              last;
  logic              accept;
  logic              issue_p0;
  logic              last_p0;
  logic              mirror_sel;

  // start is ignored during the done cycle so a back-to-back request cannot restart early
  assign accept     = (state == IDLE) && start && !done;
  assign issue_p0   = (state == SCAN) && enable;
  assign last_p0    = issue_p0 && last;
  // The address generator needs the incoming mirror while clearing, the latched one while scanning
  assign mirror_sel = (state == IDLE) ? mirror : mirror_l;

  sprite_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .ADDR_W(ADDR_W),
    .CX_W  (CX_W),
    .CY_W  (CY_W)
  ) u_addr_gen (
    .clock   (clock),
    .reset_c (reset_c),
    .clr     (accept),
    .adv     (issue_p0),
    .mirror_l(mirror_sel),
    .cx      (cx),
    .cy      (cy),
    .rom_addr(rom_addr),
    .last    (last)
  );

  // Scan control: request latching, IDLE/SCAN sequencing, busy and done flags
  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      state      <= IDLE;
      origin_x_l <= '0;
      origin_y_l <= '0;
      mirror_l   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= last_p0;
      busy <= accept || (state == SCAN);
      case (state)
        IDLE: begin
          if (accept) begin
            origin_x_l <= origin_x;
            origin_y_l <= origin_y;
            mirror_l   <= mirror;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (last_p0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: one cycle to line up with the synchronous ROM data ----
  // Screen coordinates wrap modulo the coordinate width and never mirror
  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      plot  <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      plot <= issue_p0;
      if (issue_p0) begin
        pix_x <= origin_x_l + X_BITS'(cx);
        pix_y <= origin_y_l + Y_BITS'(cy);
      end
    end
  end

endmodule

// File: tb/tb_sprite_raster_scanner.sv
// Self-checking bench for sprite_raster_scanner (4x3 sprite, 8/7-bit screen).
module tb_sprite_raster_scanner;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset_c;
  logic       start;
  logic       enable;
  logic       mirror;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       plot;

  sprite_raster_scanner #(
    .SPR_W (W),
    .SPR_H (H),
    .X_BITS(8),
    .Y_BITS(7)
  ) dut (
    .clock   (clock),
    .reset_c (reset_c),
    .start   (start),
    .enable  (enable),
    .mirror  (mirror),
    .origin_x(origin_x),
    .origin_y(origin_y),
    .busy    (busy),
    .done    (done),
    .rom_addr(rom_addr),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .plot    (plot)
  );

  always #5 clock = ~clock;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state: which pixel index is next, and what the outputs should show
  bit act;
  int k;
  int lox, loy;
  bit lmir;
  bit done_m, plot_m, busy_m;
  int px_m, py_m;
  int n_plots;
  int q_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int idx, input bit m);
    int row, col;
    row = idx / W;
    col = idx % W;
    return row * W + (m ? (W - 1 - col) : col);
  endfunction

  // One clock cycle: drive inputs, advance the model across the edge, check at the falling edge
  task automatic step(input bit st, input bit en);
    bit was_done;
    start  = st;
    enable = en;
    if (act && en) q_addr.push_back(int'(rom_addr));
    @(posedge clock);
    was_done = done_m;
    done_m   = 0;
    plot_m   = 0;
    if (act) begin
      if (en) begin
        plot_m = 1;
        px_m   = (lox + k % W) % 256;
        py_m   = (loy + k / W) % 128;
        if (k == N - 1) begin
          done_m = 1;
          act    = 0;
        end
        k++;
        n_plots++;
      end
    end else if (st && !was_done) begin
      act  = 1;
      k    = 0;
      lox  = origin_x;
      loy  = origin_y;
      lmir = mirror;
    end
    busy_m = act || done_m;
    @(negedge clock);
    chk("plot", plot, plot_m);
    chk("done", done, done_m);
    chk("busy", busy, busy_m);
    chk("pix_x", pix_x, px_m);
    chk("pix_y", pix_y, py_m);
    if (act) chk("rom_addr", rom_addr, addr_of(k, lmir));
  endtask

  // Start one scan and run it to done; stall_mode 0 none, 1 three cycles after 5th issue, 2 random
  task automatic run_scan(input int ox, input int oy, input bit mir, input int stall_mode,
                          output int latency);
    int stalls;
    bit en;
    origin_x = 8'(ox);
    origin_y = 7'(oy);
    mirror   = mir;
    n_plots  = 0;
    stalls   = 0;
    q_addr.delete();
    step(1'b1, 1'b1);
    latency = 1;
    while (!done_m && latency < 200) begin
      en = 1;
      if (stall_mode == 1 && n_plots == 5 && stalls < 3) begin en = 0; stalls++; end
      if (stall_mode == 2) en = ($urandom_range(0, 3) != 0);
      step(1'b0, en);
      latency++;
    end
    chk("scan_done_seen", done_m, 1);
    chk("plot_count", n_plots, N);
  endtask

  int lat;
  int exp_mirror[12] = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8};

  initial begin
    reset_c  = 1'b1;
    start    = 1'b0;
    enable   = 1'b0;
    mirror   = 1'b0;
    origin_x = '0;
    origin_y = '0;
    act = 0; k = 0; done_m = 0; plot_m = 0; busy_m = 0; px_m = 0; py_m = 0;
    repeat (2) @(negedge clock);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    reset_c = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Plain scan from (10,20)
    run_scan(10, 20, 1'b0, 0, lat);
    chk("t1_latency", lat, N + 1);
    chk("t1_last_x", pix_x, 13);
    chk("t1_last_y", pix_y, 22);
    for (int i = 0; i < N; i++) chk("t1_addr_seq", q_addr[i], i);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Mirrored scan from (0,0)
    run_scan(0, 0, 1'b1, 0, lat);
    for (int i = 0; i < N; i++) chk("t2_addr_seq", q_addr[i], exp_mirror[i]);
    step(1'b0, 1'b1);

    // Three stall cycles after the 5th issue
    run_scan(30, 40, 1'b0, 1, lat);
    chk("t3_latency", lat, N + 4);
    step(1'b0, 1'b1);

    // Coordinate wrap
    run_scan(254, 126, 1'b0, 0, lat);
    chk("t4_last_x", pix_x, 1);
    chk("t4_last_y", pix_y, 0);
    step(1'b0, 1'b1);

    // Asynchronous reset mid-scan, then a full scan
    origin_x = 8'd5; origin_y = 7'd6; mirror = 1'b1; n_plots = 0;
    step(1'b1, 1'b1);
    while (n_plots < 6) step(1'b0, 1'b1);
    #2 reset_c = 1'b1;
    #1;
    chk("t5_plot", plot, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_addr", rom_addr, 0);
    chk("t5_pix_x", pix_x, 0);
    chk("t5_pix_y", pix_y, 0);
    act = 0; done_m = 0; plot_m = 0; busy_m = 0; px_m = 0; py_m = 0;
    @(negedge clock);
    reset_c = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_scan(7, 9, 1'b0, 0, lat);
    chk("t5_latency", lat, N + 1);
    step(1'b0, 1'b1);

    // start during SCAN and in the done cycle is ignored; the next one is taken
    origin_x = 8'd50; origin_y = 7'd60; mirror = 1'b0; n_plots = 0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    origin_x = 8'd99; origin_y = 7'd99; mirror = 1'b1;
    step(1'b1, 1'b1);
    while (!done_m && n_plots < 50) step(1'b0, 1'b1);
    chk("t6_plot_count", n_plots, N);
    origin_x = 8'd77; origin_y = 7'd77;
    step(1'b1, 1'b0);
    chk("t6_no_restart_busy", busy, 0);
    run_scan(120, 33, 1'b1, 0, lat);
    chk("t6_latency", lat, N + 1);
    step(1'b0, 1'b1);

    // Randomized scans
    for (int r = 0; r < 4; r++) begin
      run_scan($urandom_range(0, 255), $urandom_range(0, 127), 1'($urandom_range(0, 1)), 2, lat);
      step(1'b0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
